// File: rtl/sum_block_accumulator.sv
// sum_block_accumulator
// Collects BLOCK_LEN unsigned sum samples over a valid/ready input and
// reports each block's total, maximum and a wrap flag on a registered
// valid/ready output. The result is held until the consumer accepts it.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous abort of the partial block (no effect in HOLD)
//   in_valid   in_sum carries a sample this cycle
//   in_ready   block can take a sample (decoded from state only)
//   in_sum     unsigned sample
//   out_valid  block result valid
//   out_ready  consumer accepts the result
//   out_total  sum of the block's samples, modulo 2^ACC_W
//   out_max    largest sample of the block
//   out_ovf    accumulator wrapped while building this block
//   count      samples accepted in the current partial block
module sum_block_accumulator #(
    parameter int unsigned IN_W      = 10,
    parameter int unsigned BLOCK_LEN = 4,
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [IN_W-1:0]  out_max,
    output logic             out_ovf,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned SUM_W = ACC_W + 1;

    if (BLOCK_LEN < 2 || BLOCK_LEN > 255) begin : g_bad_block_len
        $error("sum_block_accumulator: BLOCK_LEN must be within 2..255");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [IN_W-1:0]    max_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   count_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_total_q;
    logic [IN_W-1:0]    out_max_q;
    logic               out_ovf_q;

    logic [SUM_W-1:0]   sum_c;
    logic [ACC_W-1:0]   acc_d;
    logic [IN_W-1:0]    max_d;
    logic               ovf_d;
    logic               last_c;

    // Running values including the sample offered this cycle; the extra
    // sum bit is the carry out of the accumulator.
    always_comb begin
        sum_c  = {1'b0, acc_q} + SUM_W'(in_sum);
        acc_d  = sum_c[ACC_W-1:0];
        max_d  = (in_sum > max_q) ? in_sum : max_q;
        ovf_d  = ovf_q | sum_c[ACC_W];
        last_c = (count_q == CNT_W'(BLOCK_LEN - 1));
    end

    // Block FSM with accumulator and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            max_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_max_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (flush) begin
                        // Flush wins over a sample offered in the same cycle.
                        acc_q   <= '0;
                        max_q   <= '0;
                        ovf_q   <= 1'b0;
                        count_q <= '0;
                    end else if (in_valid) begin
                        if (last_c) begin
                            out_total_q <= acc_d;
                            out_max_q   <= max_d;
                            out_ovf_q   <= ovf_d;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                            acc_q       <= '0;
                            max_q       <= '0;
                            ovf_q       <= 1'b0;
                            count_q     <= '0;
                        end else begin
                            acc_q   <= acc_d;
                            max_q   <= max_d;
                            ovf_q   <= ovf_d;
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Result stays put until accepted; input side is stalled.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ACCUM;
                    end
                end
            endcase
        end
    end

    // Decoded from state only so there is no path from in_valid.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = out_valid_q;
    assign out_total = out_total_q;
    assign out_max   = out_max_q;
    assign out_ovf   = out_ovf_q;
    assign count     = count_q;

endmodule

// File: doc/sum_block_accumulator.md
Name: sum_block_accumulator

Overview:
- Downstream consumer of the adders tree's 10-bit sum3 output.
- Accepts sum samples over a valid/ready handshake and accumulates blocks of BLOCK_LEN samples.
- Per completed block, presents the block total and block maximum on a registered valid/ready output.
- Holds the result until the downstream consumer accepts it.

Parameters:
- IN_W, 10, width of each incoming sum sample (matches sum3).
- BLOCK_LEN, 4, samples per block; legal range 2..255.
- ACC_W, 12, accumulator/total width; IN_W + ceil(log2(BLOCK_LEN)) guarantees no overflow.
- CNT_W, 8, sample counter width.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort: discards the partial block.
- in_valid  input  1  in_sum is valid this cycle.
- in_ready  output  1  block can accept a sample this cycle.
- in_sum  input  IN_W  unsigned sample (sum3 from adders tree).
- out_valid  output  1  block result valid.
- out_ready  input  1  consumer accepts result.
- out_total  output  ACC_W  unsigned sum of the block's samples.
- out_max  output  IN_W  largest sample in the block.
- out_ovf  output  1  accumulator wrapped during this block (only possible when ACC_W is undersized).
- count  output  CNT_W  samples accepted in the current partial block.

Behaviour:
- Reset (async, immediate): state=ACCUM, acc=0, max=0, count=0, out_valid=0, out_total=0, out_max=0, out_ovf=0. in_ready=1 once rst deasserts.
- FSM states: ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A sample is accepted on a rising edge with in_valid&&in_ready.
  - On accept: acc <= acc+in_sum (mod 2^ACC_W; carry out sets the sticky ovf bit), max <= max(max,in_sum), count <= count+1.
- Block completion (accept with count==BLOCK_LEN-1), same edge:
  - out_total <= acc+in_sum.
  - out_max <= max(max,in_sum).
  - out_ovf <= ovf | carry.
  - out_valid <= 1, state <= HOLD.
  - acc, max, ovf and count cleared.
  - Latency: result visible the cycle after the last sample is accepted.
- HOLD:
  - in_ready=0; in_valid is ignored.
  - out_total, out_max and out_ovf are stable while out_valid=1 && !out_ready.
  - On out_valid&&out_ready: out_valid <= 0, state <= ACCUM. This costs one bubble cycle before the next sample can be accepted.
- in_ready is combinational from state only, never from in_valid, so there is no combinational loop with the upstream stage.
- flush:
  - In ACCUM: clears acc, max, ovf and count; any sample offered in the same cycle is dropped (flush wins).
  - In HOLD: no effect; the pending result is still delivered.
- Equal samples: max keeps its value; ties are irrelevant.
- in_sum=0 is a valid sample and counts toward BLOCK_LEN.
- Reset mid-block or mid-HOLD: all state is lost, out_valid drops immediately, and the pending result is discarded.
- count wraps never: it clears at BLOCK_LEN, and BLOCK_LEN ≤ 255 is enforced by the parameter range.

Test Plan:
- Basic block:
  - Stimulus: rst pulse, then samples 259, 42, 176, 99 (sum3 of vectors {0,3,1,255}, {10,13,9,10}, {15,15,109,37}, {0,9,45,45}) back-to-back, out_ready=1.
  - Response: out_valid one cycle after the 4th accept, out_total=576, out_max=259, out_ovf=0, count back to 0.
- Backpressure:
  - Stimulus: same block with out_ready=0 for 5 cycles, in_valid held high with 500.
  - Response: in_ready=0 and outputs stable (576/259) for all 5 cycles; 500 is not accepted until one cycle after the out_ready handshake.
- Input gaps:
  - Stimulus: samples 1, 2, 3, 4 with in_valid low for 2 cycles between each.
  - Response: count steps 1, 2, 3, then result out_total=10, out_max=4.
- Flush:
  - Stimulus: accept 700, 700, then flush together with in_valid (600), then 1, 1, 1, 1.
  - Response: out_total=4, out_max=1 (700s and 600 discarded).
- Overflow (ACC_W=10 build):
  - Stimulus: 1023, 1023, 1, 0.
  - Response: out_total=(2047 mod 1024)=1023, out_ovf=1, out_max=1023.
- Async reset in HOLD:
  - Stimulus: assert rst between clock edges while out_valid=1.
  - Response: out_valid, out_total and out_max go to 0 without waiting for a clock edge; the next block accumulates from 0.
